// File: rtl/aftab_llu_arbiter.sv
// aftab_llu_arbiter
// Shares one combinational logic unit (LLU) between the core datapath
// (requester 0) and the debugger (requester 1). One operation is in flight at
// a time. Each operation goes through grant, issue and hold, and the result is
// held until the owning requester consumes it. A 1-bit pointer alternates
// priority when both requesters ask in the same cycle.
module aftab_llu_arbiter #(
  parameter int size = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  input  logic            req1_valid,
  output logic            req0_ready,
  output logic            req1_ready,
  input  logic [size-1:0] req0_a,
  input  logic [size-1:0] req0_b,
  input  logic [size-1:0] req1_a,
  input  logic [size-1:0] req1_b,
  input  logic [1:0]      req0_sel,
  input  logic [1:0]      req1_sel,
  output logic [size-1:0] llu_a,
  output logic [size-1:0] llu_b,
  output logic [1:0]      llu_sel,
  input  logic [size-1:0] llu_result,
  output logic            resp0_valid,
  output logic            resp1_valid,
  input  logic            resp0_ready,
  input  logic            resp1_ready,
  output logic [size-1:0] result
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    HOLD  = 2'b10
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_ptr;          // requester favoured on a tie
  logic            r_gnt;          // owner of the operation in flight
  logic [size-1:0] r_a;
  logic [size-1:0] r_b;
  logic [1:0]      r_sel;
  logic [size-1:0] r_result;
  logic            r_resp0_valid;
  logic            r_resp1_valid;

  logic            w_accept;       // a request is taken on this edge
  logic            w_gnt;          // requester chosen this cycle
  logic            w_done;         // owner consumes the held result on this edge

  // Next state, grant choice and request handshakes.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path through
    // the case leaves it unassigned, which would infer a latch.
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_gnt       = r_ptr;
    w_done      = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    unique case (r_state)
      IDLE: begin
        // Readies are gated by rst so nothing is offered while reset is held.
        if (rst && (req0_valid || req1_valid)) begin
          w_accept    = 1'b1;
          w_gnt       = (req0_valid && req1_valid) ? r_ptr : req1_valid;
          req0_ready  = ~w_gnt;
          req1_ready  = w_gnt;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        w_state_nxt = HOLD;
      end
      HOLD: begin
        // Only the owner's ready counts; the other requester is ignored.
        if (r_gnt ? resp1_ready : resp0_ready) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand capture, result register, response flags and priority pointer.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: datapath registers are reset too, because the LLU drive and the
    // result output must read zero while reset is held.
    if (!rst) begin
      r_ptr         <= 1'b0;
      r_gnt         <= 1'b0;
      r_a           <= '0;
      r_b           <= '0;
      r_sel         <= 2'b00;
      r_result      <= '0;
      r_resp0_valid <= 1'b0;
      r_resp1_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_gnt <= w_gnt;
        r_a   <= w_gnt ? req1_a   : req0_a;
        r_b   <= w_gnt ? req1_b   : req0_b;
        r_sel <= w_gnt ? req1_sel : req0_sel;
      end
      if (r_state == ISSUE) begin
        r_result      <= llu_result;
        r_resp0_valid <= ~r_gnt;
        r_resp1_valid <= r_gnt;
      end
      if (w_done) begin
        r_resp0_valid <= 1'b0;
        r_resp1_valid <= 1'b0;
        r_ptr         <= ~r_gnt;
      end
    end
  end

  // The LLU only ever sees registered operands, never live request inputs.
  assign llu_a       = r_a;
  assign llu_b       = r_b;
  assign llu_sel     = r_sel;
  assign result      = r_result;
  assign resp0_valid = r_resp0_valid;
  assign resp1_valid = r_resp1_valid;

endmodule

// File: tb/tb_aftab_llu_arbiter.sv
// Testbench for aftab_llu_arbiter. Provides the shared logic unit, a
// transaction-level model that predicts every output each cycle, and directed
// scenarios with hand-computed expected results.
module tb_aftab_llu_arbiter;

  localparam int SIZE = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            req0_valid = 1'b0, req1_valid = 1'b0;
  logic            req0_ready, req1_ready;
  logic [SIZE-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [1:0]      req0_sel = 2'b00, req1_sel = 2'b00;
  logic [SIZE-1:0] llu_a, llu_b, llu_result, result;
  logic [1:0]      llu_sel;
  logic            resp0_valid, resp1_valid;
  logic            resp0_ready = 1'b0, resp1_ready = 1'b0;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Grant log written by the model process: owner and cycle of each accept.
  bit gq[$];
  int gc[$];

  aftab_llu_arbiter #(.size(SIZE)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_sel(req0_sel), .req1_sel(req1_sel),
    .llu_a(llu_a), .llu_b(llu_b), .llu_sel(llu_sel), .llu_result(llu_result),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
    .resp0_ready(resp0_ready), .resp1_ready(resp1_ready),
    .result(result)
  );

  always #5 clk = ~clk;

  // Reference logic function: 00 xor, 10 or, 11 and, 01 zero.
  function automatic logic [SIZE-1:0] lu(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                                         input logic [1:0] s);
    case (s)
      2'b00:   return a ^ b;
      2'b10:   return a | b;
      2'b11:   return a & b;
      default: return '0;
    endcase
  endfunction

  // The shared logic unit seen by the DUT.
  assign llu_result = lu(llu_a, llu_b, llu_sel);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: "busy" means an operation is owned; "age" counts whether its result
  // has been produced yet. Expected result comes from the request operands.
  // ---------------------------------------------------------------------------
  bit              m_busy = 0, m_owner = 0, m_age = 0, m_ptr = 0;
  logic [SIZE-1:0] m_pend = '0, m_res = '0, m_a = '0, m_b = '0;
  logic [1:0]      m_sel = 2'b00;
  bit              n_busy = 0, n_owner = 0, n_age = 0, n_ptr = 0;
  logic [SIZE-1:0] n_pend = '0, n_res = '0, n_a = '0, n_b = '0;
  logic [1:0]      n_sel = 2'b00;

  // Commit the model's next state on each edge; reset clears it immediately.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 0; m_owner <= 0; m_age <= 0; m_ptr <= 0;
      m_pend <= '0; m_res <= '0; m_a <= '0; m_b <= '0; m_sel <= 2'b00;
    end else begin
      cyc    <= cyc + 1;
      m_busy <= n_busy; m_owner <= n_owner; m_age <= n_age; m_ptr <= n_ptr;
      m_pend <= n_pend; m_res <= n_res; m_a <= n_a; m_b <= n_b; m_sel <= n_sel;
    end
  end

  // Mid-cycle compare of every output against the model, plus next-state calc.
  always @(negedge clk) begin : model_cmp
    logic            e_r0, e_r1, e_v0, e_v1, g;
    bit              t_busy, t_owner, t_age, t_ptr;
    logic [SIZE-1:0] t_pend, t_res, t_a, t_b;
    logic [1:0]      t_sel;
    e_r0 = 0; e_r1 = 0; e_v0 = 0; e_v1 = 0;
    t_busy = m_busy; t_owner = m_owner; t_age = m_age; t_ptr = m_ptr;
    t_pend = m_pend; t_res = m_res; t_a = m_a; t_b = m_b; t_sel = m_sel;
    if (rst) begin
      if (!m_busy) begin
        if (req0_valid || req1_valid) begin
          g      = (req0_valid && req1_valid) ? m_ptr : req1_valid;
          e_r0   = !g;
          e_r1   = g;
          t_busy = 1; t_owner = g; t_age = 0;
          t_a    = g ? req1_a : req0_a;
          t_b    = g ? req1_b : req0_b;
          t_sel  = g ? req1_sel : req0_sel;
          t_pend = lu(t_a, t_b, t_sel);
          gq.push_back(g);
          gc.push_back(cyc);
        end
      end else if (!m_age) begin
        t_age = 1;
        t_res = m_pend;
      end else begin
        e_v0 = !m_owner;
        e_v1 = m_owner;
        if (m_owner ? resp1_ready : resp0_ready) begin
          t_busy = 0;
          t_ptr  = !m_owner;
        end
      end
    end
    check("req0_ready",  req0_ready,  e_r0);
    check("req1_ready",  req1_ready,  e_r1);
    check("resp0_valid", resp0_valid, e_v0);
    check("resp1_valid", resp1_valid, e_v1);
    check("result",      result,      m_res);
    check("llu_a",       llu_a,       m_a);
    check("llu_b",       llu_b,       m_b);
    check("llu_sel",     llu_sel,     m_sel);
    check("resp_mutex",  resp0_valid & resp1_valid, 0);
    n_busy <= t_busy; n_owner <= t_owner; n_age <= t_age; n_ptr <= t_ptr;
    n_pend <= t_pend; n_res <= t_res; n_a <= t_a; n_b <= t_b; n_sel <= t_sel;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input bit n, output int at);
    bit seen = 0;
    at = -1;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      seen = n ? req1_ready : req0_ready;
    end
    if (seen) at = cyc;
    check($sformatf("ready%0d_seen", n), seen, 1);
  endtask

  task automatic wait_resp(input bit n, output logic [SIZE-1:0] res, output int at);
    bit seen = 0;
    at  = -1;
    res = '0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      seen = n ? resp1_valid : resp0_valid;
    end
    if (seen) begin
      at  = cyc;
      res = result;
    end
    check($sformatf("resp%0d_seen", n), seen, 1);
  endtask

  task automatic set_req(input bit n, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                         input logic [1:0] s);
    if (n) begin req1_a = a; req1_b = b; req1_sel = s; req1_valid = 1; end
    else   begin req0_a = a; req0_b = b; req0_sel = s; req0_valid = 1; end
  endtask

  task automatic run_one(input string name, input bit n, input logic [SIZE-1:0] a,
                         input logic [SIZE-1:0] b, input logic [1:0] s,
                         input logic [SIZE-1:0] exp);
    int t0, t1;
    logic [SIZE-1:0] r;
    set_req(n, a, b, s);
    wait_ready(n, t0);
    tick();
    if (n) req1_valid = 0; else req0_valid = 0;
    wait_resp(n, r, t1);
    check(name, r, exp);
    check({name, "_latency"}, t1 - t0, 2);
  endtask

  task automatic do_reset();
    tick();
    rst = 0;
    repeat (2) @(negedge clk);
    tick();
    rst = 1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  initial begin : stim
    int t0, t1;
    logic [SIZE-1:0] r, held;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_flags", {req0_ready, req1_ready, resp0_valid, resp1_valid, llu_sel}, 0);
    check("rst_result", result, 0);
    check("rst_llu_a", llu_a, 0);

    // Single request; first accept on the first edge with rst high
    tick();
    resp0_ready = 1; resp1_ready = 1;
    set_req(0, 32'hF0F0F0F0, 32'h0F0F00FF, 2'b00);
    #2 rst = 1;
    #1 check("first_accept_ready", req0_ready, 1);
    wait_ready(0, t0);
    tick();
    req0_valid = 0;
    wait_resp(0, r, t1);
    check("single_xor", r, 32'hFFFFF00F);
    check("single_latency", t1 - t0, 2);

    // Contention after reset: req0 first, then req1, then req0 again
    do_reset();
    set_req(0, 32'h00FF00FF, 32'h0000FFFF, 2'b11);
    set_req(1, 32'hFFFF0000, 32'h12345678, 2'b11);
    wait_ready(0, t0);
    check("contend_req1_not_ready", req1_ready, 0);
    tick();
    req0_valid = 0;
    wait_resp(0, r, t1);
    check("contend_res0", r, 32'h000000FF);
    wait_ready(1, t0);
    tick();
    req1_valid = 0;
    wait_resp(1, r, t1);
    check("contend_res1", r, 32'h12340000);
    tick();
    set_req(0, 32'h0000000F, 32'h000000F0, 2'b10);
    set_req(1, 32'h11111111, 32'h22222222, 2'b10);
    @(negedge clk);
    check("third_grant_req0", {req0_ready, req1_ready}, 2'b10);
    tick();
    req0_valid = 0; req1_valid = 0;
    wait_resp(0, r, t1);
    check("third_res0", r, 32'h000000FF);

    // Backpressure on requester 1 while requester 0 keeps asking
    tick();
    resp0_ready = 1; resp1_ready = 0;
    set_req(1, 32'h0000FFFF, 32'h00FF00FF, 2'b00);
    wait_ready(1, t0);
    tick();
    req1_valid = 0;
    set_req(0, 32'h0000000F, 32'h000000F0, 2'b10);
    wait_resp(1, held, t1);
    check("bp_res1", held, 32'h00FFFF00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_resp1_held", resp1_valid, 1);
      check("bp_result_stable", result, held);
      check("bp_no_grant", req0_ready, 0);
    end
    tick();
    resp1_ready = 1;
    wait_ready(0, t0);
    tick();
    req0_valid = 0;
    wait_resp(0, r, t1);
    check("bp_res0", r, 32'h000000FF);

    // OR select and the zero select
    tick();
    run_one("sel_or", 0, 32'h00000001, 32'h80000000, 2'b10, 32'h80000001);
    tick();
    run_one("sel_zero", 0, 32'h00000001, 32'h80000000, 2'b01, 32'h00000000);

    // Reset while holding a response for requester 0
    tick();
    resp0_ready = 0;
    set_req(0, 32'hAAAA5555, 32'hFFFF0000, 2'b11);
    wait_ready(0, t0);
    tick();
    req0_valid = 0;
    wait_resp(0, r, t1);
    check("hold_res0", r, 32'hAAAA0000);
    #2 rst = 0;
    #1 check("async_rst_flags", {req0_ready, req1_ready, resp0_valid, resp1_valid, llu_sel}, 0);
    check("async_rst_result", result, 0);
    check("async_rst_llu", {llu_a, llu_b}, 0);
    @(negedge clk);
    tick();
    resp0_ready = 1; resp1_ready = 1;
    set_req(0, 32'h0000FF00, 32'h00FF0000, 2'b10);
    set_req(1, 32'h12121212, 32'h34343434, 2'b00);
    #2 rst = 1;
    #1 check("post_rst_ptr_req0", {req0_ready, req1_ready, resp0_valid}, 3'b100);
    tick();
    req0_valid = 0; req1_valid = 0;
    wait_resp(0, r, t1);
    check("post_rst_res0", r, 32'h00FFFF00);

    // Continuous dual valids: alternating grants at 3-cycle spacing
    do_reset();
    gq.delete();
    gc.delete();
    set_req(0, 32'h0F0F0F0F, 32'h00000000, 2'b10);
    set_req(1, 32'hF0F0F0F0, 32'hFFFFFFFF, 2'b11);
    repeat (12) @(negedge clk);
    tick();
    req0_valid = 0; req1_valid = 0;
    repeat (4) @(negedge clk);
    check("alt_grant_count", gq.size(), 4);
    for (int i = 0; i < gq.size() && i < 4; i++) begin
      check($sformatf("alt_owner_%0d", i), gq[i], i % 2);
      check($sformatf("alt_spacing_%0d", i), gc[i] - gc[0], 3 * i);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Bound the run in case the DUT stalls somewhere unexpected.
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
